// File: rtl/collision_pkg.sv
// Shared types for the collision dispatcher: FSM state encoding, the
// obstacle vertex-array type and the minimum vertex count for a real polygon.
package collision_pkg;

  localparam int OBS_VERTICES = 5;
  localparam int OBS_COORD_W  = 8;
  localparam int MIN_VERTICES = 3;

  typedef enum logic [3:0] {
    IDLE,
    PT_FETCH,
    PT_LOAD,
    OBS_FETCH,
    OBS_LOAD,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } dispatch_state_t;

  typedef logic [1:0][OBS_VERTICES-1:0][OBS_COORD_W-1:0] obstacle_t;

endpackage

// File: rtl/collision_dispatcher.sv
// Per-frame initiator: walks every point against every obstacle, issues one
// collision request per usable obstacle, chains hits and writes results back.
module collision_dispatcher
  import collision_pkg::*;
#(
  parameter int NUM_POINTS    = 8,
  parameter int NUM_OBSTACLES = 4,
  parameter int NUM_VERTICES  = OBS_VERTICES,
  parameter int POSITION_SIZE = OBS_COORD_W,
  parameter int VELOCITY_SIZE = 8,
  parameter int DT            = 1,
  localparam int PT_W  = $clog2(NUM_POINTS),
  localparam int OBS_W = $clog2(NUM_OBSTACLES)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic                     busy_out,
  output logic                     done_out,

  output logic [PT_W-1:0]          pt_addr_out,
  input  logic [POSITION_SIZE-1:0] pt_pos_x_in,
  input  logic [POSITION_SIZE-1:0] pt_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] pt_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] pt_vel_y_in,

  output logic [OBS_W-1:0]         obs_addr_out,
  input  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0] obs_vertices_in,
  input  logic [POSITION_SIZE-1:0] obs_num_vertices_in,

  output logic                     coll_begin_out,
  output logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0] coll_obstacle_out,
  output logic [POSITION_SIZE-1:0] coll_num_vertices_out,
  output logic [POSITION_SIZE-1:0] coll_pos_x_out,
  output logic [POSITION_SIZE-1:0] coll_pos_y_out,
  output logic [POSITION_SIZE-1:0] coll_dx_out,
  output logic [POSITION_SIZE-1:0] coll_dy_out,
  output logic [VELOCITY_SIZE-1:0] coll_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] coll_vel_y_out,
  input  logic                     coll_result_in,
  input  logic                     coll_was_collision_in,
  input  logic [POSITION_SIZE-1:0] coll_x_new_in,
  input  logic [POSITION_SIZE-1:0] coll_y_new_in,
  input  logic [POSITION_SIZE-1:0] coll_x_int_in,
  input  logic [POSITION_SIZE-1:0] coll_y_int_in,
  input  logic [VELOCITY_SIZE-1:0] coll_vel_x_new_in,
  input  logic [VELOCITY_SIZE-1:0] coll_vel_y_new_in,

  output logic                     wr_en_out,
  output logic [PT_W-1:0]          wr_addr_out,
  output logic [POSITION_SIZE-1:0] wr_pos_x_out,
  output logic [POSITION_SIZE-1:0] wr_pos_y_out,
  output logic [VELOCITY_SIZE-1:0] wr_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] wr_vel_y_out
);

  dispatch_state_t state_q, state_d;
  logic [PT_W-1:0]          pt_idx_q, pt_idx_d;
  logic [OBS_W-1:0]         obs_idx_q, obs_idx_d;
  logic [POSITION_SIZE-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [POSITION_SIZE-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [VELOCITY_SIZE-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [POSITION_SIZE-1:0] fin_x_q, fin_x_d, fin_y_q, fin_y_d;
  logic                     hit_q, hit_d;
  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0] vert_q, vert_d;
  logic [POSITION_SIZE-1:0] nv_q, nv_d;
  logic                     advance_obs;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    pt_idx_d    = pt_idx_q;
    obs_idx_d   = obs_idx_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    fin_x_d     = fin_x_q;
    fin_y_d     = fin_y_q;
    hit_d       = hit_q;
    vert_d      = vert_q;
    nv_d        = nv_q;
    advance_obs = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          pt_idx_d = '0;
          state_d  = PT_FETCH;
        end
      end
      PT_FETCH: state_d = PT_LOAD;
      PT_LOAD: begin
        pos_x_d   = pt_pos_x_in;
        pos_y_d   = pt_pos_y_in;
        vel_x_d   = pt_vel_x_in;
        vel_y_d   = pt_vel_y_in;
        dx_d      = POSITION_SIZE'($signed(pt_vel_x_in) * DT);
        dy_d      = POSITION_SIZE'($signed(pt_vel_y_in) * DT);
        hit_d     = 1'b0;
        obs_idx_d = '0;
        state_d   = OBS_FETCH;
      end
      OBS_FETCH: state_d = OBS_LOAD;
      OBS_LOAD: begin
        vert_d = obs_vertices_in;
        nv_d   = obs_num_vertices_in;
        if (obs_num_vertices_in < POSITION_SIZE'(MIN_VERTICES)) advance_obs = 1'b1;
        else                                                    state_d     = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (coll_result_in) begin
          // A hit restarts the segment at the impact point; the remaining
          // travel is the bounce vector, so later obstacles see the new path.
          if (coll_was_collision_in) begin
            pos_x_d = coll_x_int_in;
            pos_y_d = coll_y_int_in;
            dx_d    = coll_x_new_in - coll_x_int_in;
            dy_d    = coll_y_new_in - coll_y_int_in;
            vel_x_d = coll_vel_x_new_in;
            vel_y_d = coll_vel_y_new_in;
            fin_x_d = coll_x_new_in;
            fin_y_d = coll_y_new_in;
            hit_d   = 1'b1;
          end
          advance_obs = 1'b1;
        end
      end
      WRITE: begin
        if (pt_idx_q == PT_W'(NUM_POINTS - 1)) begin
          state_d = DONE;
        end else begin
          pt_idx_d = pt_idx_q + PT_W'(1);
          state_d  = PT_FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance_obs) begin
      if (obs_idx_q == OBS_W'(NUM_OBSTACLES - 1)) begin
        state_d = WRITE;
      end else begin
        obs_idx_d = obs_idx_q + OBS_W'(1);
        state_d   = OBS_FETCH;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      pt_idx_q  <= '0;
      obs_idx_q <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      vel_x_q   <= '0;
      vel_y_q   <= '0;
      fin_x_q   <= '0;
      fin_y_q   <= '0;
      hit_q     <= 1'b0;
      // NOTE: the vertex register is reset because it drives coll_obstacle_out directly.
      vert_q    <= '0;
      nv_q      <= '0;
    end else begin
      state_q   <= state_d;
      pt_idx_q  <= pt_idx_d;
      obs_idx_q <= obs_idx_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
      fin_x_q   <= fin_x_d;
      fin_y_q   <= fin_y_d;
      hit_q     <= hit_d;
      vert_q    <= vert_d;
      nv_q      <= nv_d;
    end
  end

  assign busy_out       = (state_q != IDLE) && (state_q != DONE);
  assign done_out       = (state_q == DONE);
  assign coll_begin_out = (state_q == ISSUE);
  assign wr_en_out      = (state_q == WRITE);

  assign pt_addr_out  = pt_idx_q;
  assign obs_addr_out = obs_idx_q;
  assign wr_addr_out  = pt_idx_q;

  assign coll_obstacle_out     = vert_q;
  assign coll_num_vertices_out = nv_q;
  assign coll_pos_x_out        = pos_x_q;
  assign coll_pos_y_out        = pos_y_q;
  assign coll_dx_out           = dx_q;
  assign coll_dy_out           = dy_q;
  assign coll_vel_x_out        = vel_x_q;
  assign coll_vel_y_out        = vel_y_q;

  // Write data is only meaningful during the strobe and reads zero otherwise.
  assign wr_pos_x_out = !wr_en_out ? '0 : (hit_q ? fin_x_q : pos_x_q + dx_q);
  assign wr_pos_y_out = !wr_en_out ? '0 : (hit_q ? fin_y_q : pos_y_q + dy_q);
  assign wr_vel_x_out = wr_en_out ? vel_x_q : '0;
  assign wr_vel_y_out = wr_en_out ? vel_y_q : '0;

endmodule

// File: doc/collision_dispatcher.md
Name: collision_dispatcher

Overview:
Initiator side of the per-obstacle collision handshake. Once per physics frame it walks every car point against every obstacle. For each pair it drives one collision-check request, waits for the result pulse, and chains any collision into the next obstacle's segment. It then writes the final position and velocity of each point back to the point store. It sits between the frame controller, the point register file / obstacle ROM, and the per-obstacle collision unit.

Parameters:
NUM_POINTS, 8, car points processed per frame
NUM_OBSTACLES, 4, obstacles in obstacle ROM
NUM_VERTICES, 5, max vertices per obstacle (array depth)
POSITION_SIZE, 8, position/displacement width (signed)
VELOCITY_SIZE, 8, velocity width (signed)
DT, 1, integer timestep multiplier for displacement

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
start_in  in  1  frame start pulse
busy_out  out  1  high from accepted start until done
done_out  out  1  one-cycle pulse when last point written
pt_addr_out  out  $clog2(NUM_POINTS)  point read address
pt_pos_x_in, pt_pos_y_in  in  POSITION_SIZE each  point position, valid 1 cycle after address
pt_vel_x_in, pt_vel_y_in  in  VELOCITY_SIZE each  point velocity, same timing
obs_addr_out  out  $clog2(NUM_OBSTACLES)  obstacle ROM address
obs_vertices_in  in  [1:0][NUM_VERTICES-1:0] x POSITION_SIZE  vertex array, valid 1 cycle after address
obs_num_vertices_in  in  POSITION_SIZE  used vertex count
coll_begin_out  out  1  one-cycle request pulse
coll_obstacle_out, coll_num_vertices_out  out  as above  held stable from begin until result
coll_pos_x_out, coll_pos_y_out, coll_dx_out, coll_dy_out  out  POSITION_SIZE each  segment start and displacement
coll_vel_x_out, coll_vel_y_out  out  VELOCITY_SIZE each  current velocity
coll_result_in  in  1  one-cycle result pulse
coll_was_collision_in  in  1  valid with result
coll_x_new_in, coll_y_new_in, coll_x_int_in, coll_y_int_in  in  POSITION_SIZE each  valid with result
coll_vel_x_new_in, coll_vel_y_new_in  in  VELOCITY_SIZE each  valid with result
wr_en_out  out  1  write-back strobe
wr_addr_out  out  $clog2(NUM_POINTS)  write address
wr_pos_x_out, wr_pos_y_out  out  POSITION_SIZE each  final position
wr_vel_x_out, wr_vel_y_out  out  VELOCITY_SIZE each  final velocity

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, begin, wr_en, addresses, data.
- FSM: IDLE -> PT_FETCH -> PT_LOAD -> OBS_FETCH -> OBS_LOAD -> ISSUE -> WAIT -> (OBS_FETCH | WRITE) -> (PT_FETCH | DONE) -> IDLE.
- IDLE: on start_in, busy_out<=1, point idx=0, go PT_FETCH. start_in is ignored while busy.
- PT_FETCH: drive pt_addr_out.
- PT_LOAD: capture pos/vel. Compute dx = vel_x*DT and dy = vel_y*DT, truncated to POSITION_SIZE, two's complement wrap. Clear hit flag. Set obstacle idx=0.
- OBS_FETCH and OBS_LOAD: read the ROM and register the vertex array and count.
- In OBS_LOAD, if num_vertices < 3, skip the obstacle: no begin, go straight to the next-obstacle decision.
- ISSUE: coll_begin_out high exactly one cycle. Request fields are registered and held unchanged until coll_result_in.
- WAIT: hold until coll_result_in. There is no timeout. Inputs other than result are ignored while result is low.
- On result with was_collision=1:
  - pos <= x_int/y_int
  - dx <= x_new - x_int, dy <= y_new - y_int (truncated)
  - vel <= vel_new
  - final_pos <= x_new/y_new; hit <= 1
- On result with was_collision=0: state unchanged.
- Next obstacle: if idx < NUM_OBSTACLES-1, idx+1 and go OBS_FETCH. Otherwise go WRITE.
- WRITE: wr_en_out high one cycle.
  - If hit: position = final_pos, velocity = chained vel.
  - If no hit: position = pos+dx (wrap), velocity unchanged.
- After WRITE: if last point go DONE, otherwise increment point idx and go PT_FETCH.
- DONE: done_out pulses for one cycle; busy_out drops in the same cycle; return to IDLE.
- A coll_result_in arriving outside WAIT is ignored.
- rst_in mid-frame aborts immediately. No partial write and no further begin pulses; state returns to reset values next cycle.
- Cycle count per point, with W = wait cycles: 2 + sum over obstacles (2+1+W) + 1. Skipped obstacles cost 2 cycles each.

Decomposition:
- Package collision_pkg holds:
  - state enum dispatch_state_t
  - vertex array typedef obstacle_t [1:0][NUM_VERTICES-1:0]
  - constant MIN_VERTICES=3
- No sub-module. A single FSM file is sufficient. The bench provides a behavioural collision-unit responder with a programmable delay.

Test Plan:
1. NUM_POINTS=1, NUM_OBSTACLES=1. Point (10,10), vel (2,3), responder no-collision after 3 cycles -> one begin pulse; write (12,13), vel (2,3); done_out 1 cycle after write.
2. One obstacle. Responder returns collision, x_int=11, y_int=12, x_new=11, y_new=10, vel (2,-3) -> write (11,10), vel (2,-3).
3. Two obstacles. Collision on the first with x_int=11, y_int=12, x_new=13, y_new=9, vel (2,-3) -> second begin carries pos (11,12), dx=2, dy=-3, vel (2,-3). A no-collision second result -> write (13,9).
4. Obstacle with num_vertices=2 -> no begin for it; point written as pos+dx. Also check the cycle count.
5. start_in pulsed while busy, and a spurious coll_result_in in PT_LOAD -> both ignored; exactly NUM_POINTS writes and one done.
6. rst_in asserted during WAIT -> next cycle all outputs 0 and state IDLE. A following start_in processes from point 0.
